// File: rtl/cpu_pkg.sv
// Shared constants for the control sequencer: opcodes, control-word bit indices,
// named microcode words and the T-state counter width.
package cpu_pkg;

   localparam int unsigned STEP_W = 3;
   localparam int unsigned CTRL_W = 16;
   localparam int unsigned OP_W   = 4;

   localparam logic [OP_W-1:0] OP_NOP = 4'd0;
   localparam logic [OP_W-1:0] OP_LDA = 4'd1;
   localparam logic [OP_W-1:0] OP_ADD = 4'd2;
   localparam logic [OP_W-1:0] OP_SUB = 4'd3;
   localparam logic [OP_W-1:0] OP_STA = 4'd4;
   localparam logic [OP_W-1:0] OP_LDI = 4'd5;
   localparam logic [OP_W-1:0] OP_JMP = 4'd6;
   localparam logic [OP_W-1:0] OP_JC  = 4'd7;
   localparam logic [OP_W-1:0] OP_JZ  = 4'd8;
   localparam logic [OP_W-1:0] OP_OUT = 4'd14;
   localparam logic [OP_W-1:0] OP_HLT = 4'd15;

   localparam int unsigned HLT_BIT = 15;
   localparam int unsigned MI_BIT  = 14;
   localparam int unsigned RI_BIT  = 13;
   localparam int unsigned RO_BIT  = 12;
   localparam int unsigned IO_BIT  = 11;
   localparam int unsigned II_BIT  = 10;
   localparam int unsigned AI_BIT  = 9;
   localparam int unsigned AO_BIT  = 8;
   localparam int unsigned EO_BIT  = 7;
   localparam int unsigned SU_BIT  = 6;
   localparam int unsigned BI_BIT  = 5;
   localparam int unsigned OI_BIT  = 4;
   localparam int unsigned CE_BIT  = 3;
   localparam int unsigned CO_BIT  = 2;
   localparam int unsigned J_BIT   = 1;
   localparam int unsigned FI_BIT  = 0;

   localparam logic [CTRL_W-1:0] C_HLT = CTRL_W'(1) << HLT_BIT;
   localparam logic [CTRL_W-1:0] C_MI  = CTRL_W'(1) << MI_BIT;
   localparam logic [CTRL_W-1:0] C_RI  = CTRL_W'(1) << RI_BIT;
   localparam logic [CTRL_W-1:0] C_RO  = CTRL_W'(1) << RO_BIT;
   localparam logic [CTRL_W-1:0] C_IO  = CTRL_W'(1) << IO_BIT;
   localparam logic [CTRL_W-1:0] C_II  = CTRL_W'(1) << II_BIT;
   localparam logic [CTRL_W-1:0] C_AI  = CTRL_W'(1) << AI_BIT;
   localparam logic [CTRL_W-1:0] C_AO  = CTRL_W'(1) << AO_BIT;
   localparam logic [CTRL_W-1:0] C_EO  = CTRL_W'(1) << EO_BIT;
   localparam logic [CTRL_W-1:0] C_SU  = CTRL_W'(1) << SU_BIT;
   localparam logic [CTRL_W-1:0] C_BI  = CTRL_W'(1) << BI_BIT;
   localparam logic [CTRL_W-1:0] C_OI  = CTRL_W'(1) << OI_BIT;
   localparam logic [CTRL_W-1:0] C_CE  = CTRL_W'(1) << CE_BIT;
   localparam logic [CTRL_W-1:0] C_CO  = CTRL_W'(1) << CO_BIT;
   localparam logic [CTRL_W-1:0] C_J   = CTRL_W'(1) << J_BIT;
   localparam logic [CTRL_W-1:0] C_FI  = CTRL_W'(1) << FI_BIT;

   localparam logic [CTRL_W-1:0] FETCH0    = C_CO | C_MI;
   localparam logic [CTRL_W-1:0] FETCH1    = C_RO | C_II | C_CE;
   localparam logic [CTRL_W-1:0] ADDR_LOAD = C_IO | C_MI;
   localparam logic [CTRL_W-1:0] RAM_TO_A  = C_RO | C_AI;
   localparam logic [CTRL_W-1:0] RAM_TO_B  = C_RO | C_BI;
   localparam logic [CTRL_W-1:0] ALU_ADD   = C_EO | C_AI | C_FI;
   localparam logic [CTRL_W-1:0] ALU_SUB   = C_EO | C_AI | C_FI | C_SU;
   localparam logic [CTRL_W-1:0] A_TO_RAM  = C_AO | C_RI;
   localparam logic [CTRL_W-1:0] IMM_TO_A  = C_IO | C_AI;
   localparam logic [CTRL_W-1:0] JUMP      = C_IO | C_J;
   localparam logic [CTRL_W-1:0] A_TO_OUT  = C_AO | C_OI;
   localparam logic [CTRL_W-1:0] HALT      = C_HLT;
   localparam logic [CTRL_W-1:0] IDLE      = '0;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word, plus a flag marking
// the last listed T-state of the current opcode.
module microcode_rom
   import cpu_pkg::*;
#(
   parameter int unsigned OPCODE_W = 4
) (
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [STEP_W-1:0]   step,
   input  logic                carry,
   input  logic                is_zero,
   output logic [CTRL_W-1:0]   ctrl,
   output logic                last_step
);

   logic [STEP_W-1:0] last_idx;

   // Control word lookup; flags only matter in T2
   always_comb begin
      ctrl = IDLE;
      case (step)
         STEP_W'(0): ctrl = FETCH0;
         STEP_W'(1): ctrl = FETCH1;
         STEP_W'(2): begin
            case (opcode)
               OPCODE_W'(OP_LDA), OPCODE_W'(OP_ADD),
               OPCODE_W'(OP_SUB), OPCODE_W'(OP_STA): ctrl = ADDR_LOAD;
               OPCODE_W'(OP_LDI): ctrl = IMM_TO_A;
               OPCODE_W'(OP_JMP): ctrl = JUMP;
               OPCODE_W'(OP_JC):  ctrl = carry   ? JUMP : IDLE;
               OPCODE_W'(OP_JZ):  ctrl = is_zero ? JUMP : IDLE;
               OPCODE_W'(OP_OUT): ctrl = A_TO_OUT;
               OPCODE_W'(OP_HLT): ctrl = HALT;
               default:           ctrl = IDLE;
            endcase
         end
         STEP_W'(3): begin
            case (opcode)
               OPCODE_W'(OP_LDA): ctrl = RAM_TO_A;
               OPCODE_W'(OP_ADD),
               OPCODE_W'(OP_SUB): ctrl = RAM_TO_B;
               OPCODE_W'(OP_STA): ctrl = A_TO_RAM;
               default:           ctrl = IDLE;
            endcase
         end
         STEP_W'(4): begin
            case (opcode)
               OPCODE_W'(OP_ADD): ctrl = ALU_ADD;
               OPCODE_W'(OP_SUB): ctrl = ALU_SUB;
               default:           ctrl = IDLE;
            endcase
         end
         default: ctrl = IDLE;
      endcase
   end

   // Last meaningful T-state per opcode, used for early return to fetch
   always_comb begin
      last_idx = STEP_W'(2);
      case (opcode)
         OPCODE_W'(OP_LDA), OPCODE_W'(OP_STA): last_idx = STEP_W'(3);
         OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): last_idx = STEP_W'(4);
         default:                              last_idx = STEP_W'(2);
      endcase
      last_step = (step == last_idx);
   end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer for the 8-bit CPU: step counter, halt latch and microcode lookup.
// Optional macro CTRL_SHORT_CYCLE_EN returns to fetch after each opcode's last step.
module control_sequencer
   import cpu_pkg::*;
#(
   parameter int unsigned OPCODE_W  = 4,
   parameter int unsigned NUM_STEPS = 5
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                carry,
   input  logic                is_zero,
   output logic [CTRL_W-1:0]   ctrl,
   output logic [STEP_W-1:0]   step,
   output logic                halted
);

   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(NUM_STEPS - 1);

   logic [CTRL_W-1:0] rom_ctrl;
   logic              rom_last;
   logic [STEP_W-1:0] step_nxt;
   logic              halt_nxt;
   logic              wrap;

   microcode_rom #(
      .OPCODE_W (OPCODE_W)
   ) u_rom (
      .opcode    (opcode),
      .step      (step),
      .carry     (carry),
      .is_zero   (is_zero),
      .ctrl      (rom_ctrl),
      .last_step (rom_last)
   );

`ifdef CTRL_SHORT_CYCLE_EN
   assign wrap = rom_last || (step == STEP_MAX);
`else
   logic unused_rom_last;
   assign unused_rom_last = rom_last;
   assign wrap = (step == STEP_MAX);
`endif

   // Next step and halt decision
   always_comb begin
      step_nxt = step;
      halt_nxt = halted;
      if (!halted) begin
         step_nxt = wrap ? '0 : step + STEP_W'(1);
         if ((step == STEP_W'(2)) && (opcode == OPCODE_W'(OP_HLT))) begin
            halt_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         step   <= '0;
         halted <= 1'b0;
      end else begin
         step   <= step_nxt;
         halted <= halt_nxt;
      end
   end

   // Once halted the bus sees only HLT, regardless of opcode or flags
   assign ctrl = halted ? HALT : rom_ctrl;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have parameter OPCODE_W, default 4, meaning opcode width.
REQ-002 The block SHALL have parameter NUM_STEPS, default 5, meaning T-states per full instruction cycle.
REQ-003 The block SHALL have port clk, input, 1, the system clock; the block uses one clock only, and all state changes on its rising edge.
REQ-004 The block SHALL have port clr, input, 1, the reset; reset is asynchronous and active-high.
REQ-005 The block SHALL have port opcode, input, OPCODE_W, the upper nibble of the instruction register.
REQ-006 The block SHALL have port carry, input, 1, the latched ALU carry flag.
REQ-007 The block SHALL have port is_zero, input, 1, the latched ALU zero flag.
REQ-008 The block SHALL have port ctrl, output, 16, the control word, with bits HLT15 MI14 RI13 RO12 IO11 II10 AI9 AO8 EO7 SU6 BI5 OI4 CE3 CO2 J1 FI0.
REQ-009 ctrl bit EO SHALL drive the ALU en input, bit SU SHALL drive the ALU sub input, and bit FI SHALL drive the ALU flag_en input.
REQ-010 The block SHALL have port step, output, 3, the current T-state.
REQ-011 The block SHALL have port halted, output, 1, which is high once HLT has executed.

Function
REQ-012 step SHALL advance by 1 per clk edge and wrap from NUM_STEPS-1 to 0.
REQ-013 ctrl SHALL be combinational from (step, opcode, carry, is_zero, halted), with no added latency.
REQ-014 Fetch: T0 SHALL produce CO|MI (0x4004) and T1 SHALL produce RO|II|CE (0x1408), for every opcode.
REQ-015 LDA (1) SHALL produce T2 IO|MI, then T3 RO|AI.
REQ-016 ADD (2) SHALL produce T2 IO|MI, then T3 RO|BI, then T4 EO|AI|FI (0x0281).
REQ-017 SUB (3) SHALL be the same as ADD, except that T4 additionally asserts SU (0x02C1).
REQ-018 STA (4) SHALL produce T2 IO|MI, then T3 AO|RI.
REQ-019 LDI (5) SHALL produce T2 IO|AI.
REQ-020 JMP (6) SHALL produce T2 IO|J (0x0802).
REQ-021 JC (7) SHALL produce T2 IO|J when carry=1, else 0.
REQ-022 JZ (8) SHALL produce T2 IO|J when is_zero=1, else 0.
REQ-023 Flags SHALL be sampled combinationally during T2 only.
REQ-024 OUT (14) SHALL produce T2 AO|OI.
REQ-025 HLT (15) SHALL produce T2 HLT.
REQ-026 NOP (0) and the unused opcodes 9-13 SHALL produce ctrl=0 in T2-T4.
REQ-027 Any step not listed for an opcode SHALL produce ctrl=0.
REQ-028 halted SHALL set on the clk edge ending a T2 with opcode=15.
REQ-029 While halted=1, step SHALL freeze, ctrl SHALL equal 0x8000, and opcode and flag changes SHALL be ignored.
REQ-030 Only clr SHALL clear halted.
REQ-031 EO and AO SHALL never be asserted in the same cycle, so the bus has a single driver.

Reset
REQ-032 clr=1 SHALL force step=0 and halted=0 immediately, without waiting for clk.
REQ-033 During reset, ctrl SHALL equal 0x4004.
REQ-034 clr asserted mid-instruction SHALL abort it, and the next cycle after release SHALL be T0 of a fresh fetch.
REQ-035 clr SHALL take precedence over halt.

Configuration
REQ-036 The block SHALL have one macro, CTRL_SHORT_CYCLE_EN.
REQ-037 When CTRL_SHORT_CYCLE_EN is defined, step SHALL return to 0 after the last listed step of the current opcode: T2 for LDI/JMP/JC/JZ/OUT/NOP/unused opcodes, T3 for LDA/STA, and T4 for ADD/SUB.
REQ-038 When CTRL_SHORT_CYCLE_EN is undefined, every instruction SHALL run all NUM_STEPS steps.
REQ-039 A not-taken JC or JZ SHALL end after T2 when CTRL_SHORT_CYCLE_EN is defined.

Structure
REQ-040 Package cpu_pkg SHALL hold the opcode localparams, the ctrl bit indices, the named control-word constants (FETCH0, FETCH1, etc.), and the step width.
REQ-041 Sub-module microcode_rom SHALL be a purely combinational map from (opcode, step, carry, is_zero) to ctrl plus a last_step flag.
REQ-042 The top level SHALL hold the step counter, the halted register, and the short-cycle mux.

Verification
REQ-043 Reset release, opcode=2 -> step 0..4 SHALL give ctrl 0x4004, 0x1408, 0x4800, 0x1020, 0x0281, then wrap to 0.
REQ-044 opcode=3 -> T4 ctrl SHALL be 0x02C1, with SU and EO asserted together and FI=1.
REQ-045 opcode=7 with carry=1 -> T2 ctrl SHALL be 0x0802; with carry=0 -> T2 ctrl SHALL be 0x0000. Repeat for opcode=8 using is_zero.
REQ-046 opcode=15 -> after T2 halted=1, ctrl SHALL be 0x8000, and step SHALL hold for 10 clocks while opcode toggles; then clr -> step=0, halted=0, ctrl=0x4004.
REQ-047 clr pulsed asynchronously between edges during step 3 -> step SHALL be 0 before the next clk edge.
REQ-048 With CTRL_SHORT_CYCLE_EN defined, opcode=5 SHALL give the step sequence 0,1,2,0, and opcode=1 SHALL give 0,1,2,3,0.
